lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL be the maximum cycles waited for mem_ack per memory phase (legal 1..255).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  core requests a load/store; sampled only in IDLE.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; others illegal.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data, right-aligned.
REQ-009 rdata  out  32  load result, sign/zero extended.
REQ-010 busy  out  1  pipeline stall; high in every non-IDLE state.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  qualified by done: misaligned, illegal funct3, or timeout.
REQ-013 mem_addr  out  32  word address to data memory, bits [1:0] = 00.
REQ-014 mem_wdata  out  32  full word to write.
REQ-015 mem_rd  out  1  read request, held until mem_ack.
REQ-016 mem_memwr  out  1  write strobe, held until mem_ack.
REQ-017 mem_rdata  in  32  read word, valid when mem_ack high during read.
REQ-018 mem_ack  in  1  memory completion for the current phase.

Function
REQ-019 FSM states SHALL be IDLE, RD, WR, DONE; mem_rd high only in RD, mem_memwr only in WR, never both.
REQ-020 IDLE with req_valid: SHALL latch addr, wdata, funct3, req_we; next state RD for loads and SB/SH, WR for SW.
REQ-021 RD on mem_ack: SHALL capture mem_rdata; loads go to DONE, SB/SH go to WR with merged word.
REQ-022 Merge: SB replaces byte addr[1:0] with wdata[7:0]; SH replaces halfword addr[1] with wdata[15:0]; other bytes kept from read word.
REQ-023 WR on mem_ack SHALL go to DONE; mem_wdata = wdata for SW, merged word for SB/SH.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy low in IDLE only.
REQ-025 Load extraction: byte/halfword selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; rdata held stable until next load completes.
REQ-026 Latency without wait states (ack same cycle as request): LW/SW done 2 cycles after accept; SB/SH 3 cycles.
REQ-027 Per-phase counter SHALL reset on entering RD/WR; if it reaches TIMEOUT without mem_ack, abort to DONE with err=1, no further memory strobes.
REQ-028 Illegal funct3 (incl. 1xx with req_we=1) SHALL go directly IDLE->DONE with err=1, no memory access.
REQ-029 req_valid while busy SHALL be ignored; core must hold request until done.
REQ-030 mem_ack outside RD/WR SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force IDLE immediately; busy, done, err, mem_rd, mem_memwr = 0; rdata, mem_addr, mem_wdata = 0; timeout counter = 0.
REQ-032 Reset mid RD/WR SHALL drop strobes asynchronously; aborted transaction never signals done.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=00 SHALL go IDLE->DONE with err=1, no memory access.
REQ-034 Macro undefined: misaligned accesses SHALL proceed, address bits below access size forced to 0 (word and halfword truncated), err=0.

Verification
REQ-035 LW addr=0x10, ack same cycle, mem_rdata=0xDEADBEEF -> done 2 cycles after accept, rdata=0xDEADBEEF, err=0, mem_addr=0x10.
REQ-036 Word 0x11223344 at 0x20; SB addr=0x22 wdata=0xAA -> RD then WR, mem_wdata=0x11AA3344, done at cycle 3.
REQ-037 mem_rdata=0x0080FF7F: LB addr=0x1 -> 0xFFFFFFFF; LBU addr=0x3 -> 0x00000000; LH addr=0x2 -> 0x00000080; LHU addr=0x0 -> 0x0000FF7F.
REQ-038 TIMEOUT=4, SW with mem_ack never asserted -> mem_memwr high 4 cycles, then done=1 err=1, mem_memwr=0.
REQ-039 LW addr=0x6: with LSU_MISALIGN_TRAP_EN -> no mem_rd, done err=1; without -> mem_addr=0x4, err=0.
REQ-040 rst_n low during RD of SH -> mem_rd falls same cycle, no done, no write; next LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: RV32I byte/half/word access over a single-ported word memory, with
// read-modify-write for SB/SH and a per-phase ack timeout. Optional macro LSU_MISALIGN_TRAP_EN.
module lsu #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_memwr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   // state | meaning
   // IDLE  | waiting for req_valid
   // RD    | mem_rd held until ack (loads, and the read half of SB/SH)
   // WR    | mem_memwr held until ack
   // DONE  | one-cycle done pulse, err valid
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(TIMEOUT - 1);

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] wd_q;
   logic [7:0]  cnt;

   logic        illegal, misalign, bad;
   logic [1:0]  off_in;
   logic [4:0]  sh_amt;
   logic [31:0] lane, load_val, merge_val;

   always_comb begin
      illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && req_we);
      misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif
      bad = illegal || misalign;
      // Address bits below the access size are dropped, so misaligned accesses truncate.
      case (funct3[1:0])
         2'b00:   off_in = addr[1:0];
         2'b01:   off_in = {addr[1], 1'b0};
         default: off_in = 2'b00;
      endcase
   end

   always_comb begin
      sh_amt = {off_q, 3'b000};
      lane   = mem_rdata >> sh_amt;
      case (f3_q[1:0])
         2'b00: begin
            load_val  = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
            merge_val = (mem_rdata & ~(32'h0000_00FF << sh_amt)) |
                        ({24'h0, wd_q[7:0]} << sh_amt);
         end
         2'b01: begin
            load_val  = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
            merge_val = (mem_rdata & ~(32'h0000_FFFF << sh_amt)) |
                        ({16'h0, wd_q[15:0]} << sh_amt);
         end
         default: begin
            load_val  = mem_rdata;
            merge_val = wd_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         wd_q      <= 32'h0;
         cnt       <= 8'h0;
         rdata     <= 32'h0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_rd    <= 1'b0;
         mem_memwr <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  f3_q     <= funct3;
                  off_q    <= off_in;
                  wd_q     <= wdata;
                  mem_addr <= {addr[31:2], 2'b00};
                  busy     <= 1'b1;
                  cnt      <= CNT_LOAD;
                  if (bad) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (!req_we || (funct3[1:0] != 2'b10)) begin
                     state  <= RD;
                     mem_rd <= 1'b1;
                  end else begin
                     state     <= WR;
                     mem_memwr <= 1'b1;
                     mem_wdata <= wdata;
                  end
               end
            end
            RD: begin
               if (mem_ack) begin
                  mem_rd <= 1'b0;
                  if (!we_q) begin
                     rdata <= load_val;
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     mem_wdata <= merge_val;
                     mem_memwr <= 1'b1;
                     cnt       <= CNT_LOAD;
                     state     <= WR;
                  end
               end else if (cnt == 8'h0) begin
                  mem_rd <= 1'b0;
                  err    <= 1'b1;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt - 8'h1;
               end
            end
            WR: begin
               if (mem_ack || (cnt == 8'h0)) begin
                  mem_memwr <= 1'b0;
                  err       <= ~mem_ack;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 8'h1;
               end
            end
            DONE: begin
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: zero-wait memory model plus a stalled-ack mode
// for timeout and mid-transaction reset.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
   logic        busy, done, err, mem_rd, mem_memwr, mem_ack;

   logic [31:0] mem_word;
   logic        ack_en, ack_force;
   int          n_checks = 0, n_fail = 0;
   int          rd_cyc = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0;
   logic [31:0] last_wd = 32'h0, last_wa = 32'h0;
   int          cyc, n, rd0, wr0, dn0;

   lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
      .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_memwr(mem_memwr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_word;
   assign mem_ack   = ack_force | (ack_en & (mem_rd | mem_memwr));

   always @(posedge clk) begin
      if (mem_rd) rd_cyc++;
      if (done) done_cnt++;
      if (mem_rd && mem_memwr) both_cnt++;
      if (mem_memwr && mem_ack) begin
         wr_cnt++;
         last_wd = mem_wdata;
         last_wa = mem_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a request for one accept edge, then drops req_valid.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      tick();
      req_valid = 1'b0;
   endtask

   // cyc = cycles from accept (accept cycle = 0) until done is seen, bounded.
   task automatic wait_done(output int c);
      c = 1;
      while (!done && c < 20) begin
         tick();
         c++;
      end
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                       input string tag);
      issue(1'b0, f3, a, 32'h0);
      wait_done(cyc);
      chk({tag, "_rdata"}, rdata, exp);
      chk({tag, "_err"}, {31'h0, err}, 32'h0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
      addr = 32'h0; wdata = 32'h0; mem_word = 32'h0; ack_en = 1'b1; ack_force = 1'b0;
      tick(); tick();
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_strobes", {30'h0, mem_rd, mem_memwr}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_mwdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      tick();

      // LW, zero wait states
      mem_word = 32'hDEAD_BEEF;
      issue(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_rd", {31'h0, mem_rd}, 32'h1);
      chk("lw_busy", {31'h0, busy}, 32'h1);
      chk("lw_maddr", mem_addr, 32'h10);
      wait_done(cyc);
      chk("lw_lat", cyc, 2);
      chk("lw_rdata", rdata, 32'hDEAD_BEEF);
      chk("lw_err", {31'h0, err}, 32'h0);
      tick();
      chk("lw_pulse", {31'h0, done}, 32'h0);
      chk("lw_idle_busy", {31'h0, busy}, 32'h0);

      // SB / SH read-modify-write, SW direct
      mem_word = 32'h1122_3344;
      wr0 = wr_cnt;
      issue(1'b1, 3'b000, 32'h22, 32'h0000_00AA);
      wait_done(cyc);
      chk("sb_lat", cyc, 3);
      chk("sb_wdata", last_wd, 32'h11AA_3344);
      chk("sb_waddr", last_wa, 32'h20);
      chk("sb_wrs", wr_cnt - wr0, 1);
      chk("sb_err", {31'h0, err}, 32'h0);
      tick();
      issue(1'b1, 3'b001, 32'h22, 32'h1234_BEEF);
      wait_done(cyc);
      chk("sh_lat", cyc, 3);
      chk("sh_wdata", last_wd, 32'hBEEF_3344);
      tick();
      rd0 = rd_cyc;
      issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
      wait_done(cyc);
      chk("sw_lat", cyc, 2);
      chk("sw_wdata", last_wd, 32'hCAFE_F00D);
      chk("sw_no_rd", rd_cyc - rd0, 0);
      chk("sw_rdata_hold", rdata, 32'hDEAD_BEEF);
      tick();

      // Load extraction
      mem_word = 32'h0080_FF7F;
      load(3'b000, 32'h1, 32'hFFFF_FFFF, "lb1");
      load(3'b100, 32'h3, 32'h0000_0000, "lbu3");
      load(3'b001, 32'h2, 32'h0000_0080, "lh2");
      load(3'b101, 32'h0, 32'h0000_FF7F, "lhu0");
      load(3'b000, 32'h0, 32'h0000_007F, "lb0");
      load(3'b001, 32'h0, 32'hFFFF_FF7F, "lh0");

      // Illegal encodings
      rd0 = rd_cyc; wr0 = wr_cnt;
      issue(1'b0, 3'b011, 32'h0, 32'h0);
      wait_done(cyc);
      chk("ill011_lat", cyc, 1);
      chk("ill011_err", {31'h0, err}, 32'h1);
      tick();
      issue(1'b1, 3'b100, 32'h0, 32'h0);
      wait_done(cyc);
      chk("illsbu_err", {31'h0, err}, 32'h1);
      chk("ill_no_mem", (rd_cyc - rd0) + (wr_cnt - wr0), 0);
      tick();

      // Write timeout; a request presented while busy must be ignored
      ack_en = 1'b0;
      rd0 = rd_cyc; dn0 = done_cnt;
      issue(1'b1, 3'b010, 32'h40, 32'h5555_AAAA);
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h80;
      n = 0;
      while (mem_memwr && n < 20) begin
         n++;
         tick();
      end
      req_valid = 1'b0;
      chk("to_cycles", n, 4);
      chk("to_done", {31'h0, done}, 32'h1);
      chk("to_err", {31'h0, err}, 32'h1);
      chk("to_wr_low", {31'h0, mem_memwr}, 32'h0);
      chk("to_maddr", mem_addr, 32'h40);
      chk("to_no_rd", rd_cyc - rd0, 0);
      tick();
      chk("to_one_done", done_cnt - dn0, 1);
      ack_en = 1'b1;

      // Stray ack while idle
      ack_force = 1'b1;
      tick(); tick();
      ack_force = 1'b0;
      chk("stray_busy", {31'h0, busy}, 32'h0);
      chk("stray_done", {31'h0, done}, 32'h0);

      // Misaligned LW
      mem_word = 32'h600D_F00D;
      rd0 = rd_cyc;
      issue(1'b0, 3'b010, 32'h6, 32'h0);
      wait_done(cyc);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_lat", cyc, 1);
      chk("mis_err", {31'h0, err}, 32'h1);
      chk("mis_no_rd", rd_cyc - rd0, 0);
`else
      chk("mis_maddr", mem_addr, 32'h4);
      chk("mis_err", {31'h0, err}, 32'h0);
      chk("mis_rdata", rdata, 32'h600D_F00D);
`endif
      tick();

      // Reset in the read phase of SH, then a clean LW
      ack_en = 1'b0;
      wr0 = wr_cnt; dn0 = done_cnt;
      issue(1'b1, 3'b001, 32'h2, 32'h0000_1234);
      chk("rr_rd_high", {31'h0, mem_rd}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_rd_drop", {31'h0, mem_rd}, 32'h0);
      chk("rr_busy_drop", {31'h0, busy}, 32'h0);
      ack_en = 1'b1;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("rr_no_done", done_cnt - dn0, 0);
      chk("rr_no_write", wr_cnt - wr0, 0);
      mem_word = 32'h1234_5678;
      issue(1'b0, 3'b010, 32'h8, 32'h0);
      wait_done(cyc);
      chk("rr_lw_lat", cyc, 2);
      chk("rr_lw_rdata", rdata, 32'h1234_5678);
      tick();

      chk("never_both", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
